// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state encoding, requester ids and default pattern for seq_detect_sched
package seq_detect_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;
    localparam int DEF_PLEN = 6;
    localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 6'b101011;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial PLEN-bit window matcher counting overlapping pattern hits
//  clk, reset (async, active-high), clr (sync clear of history/fill/count at word start),
//  bit_valid/bit_in (serial bit stream), count (hits since last clr)
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PLEN = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);
    localparam int FW = $clog2(PLEN);
    logic [PLEN-1:0] hist, hist_next;
    logic [FW-1:0] fill;
    logic full, hit;
    // fill saturates at PLEN-1: once reached, the incoming bit completes a full window
    always_comb begin
        hist_next = {hist[PLEN-2:0], bit_in};
        full = fill == FW'(PLEN-1);
        hit = full && hist_next == PATTERN;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
            count <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
            count <= '0;
        end else if (bit_valid) begin
            hist <= hist_next;
            fill <= full ? fill : fill + 1'b1;
            count <= hit ? count + 1'b1 : count;
        end
    end
endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin shares one serial pattern matcher between requesters A and B
//  clk, reset (async, active-high)
//  a_valid/a_data/a_ready, b_valid/b_data/b_ready: word requesters, accepted when valid & ready
//  bit_valid/bit_out: serial bit fed to the matcher (MSB-first)
//  res_valid/res_id/res_count: one-cycle result pulse with requester id and match count
//  busy: high while shifting or reporting
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PLEN = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
    localparam int CNT_W = $clog2(DATA_W-PLEN+2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              res_valid,
    output logic              res_id,
    output logic [CNT_W-1:0]  res_count,
    output logic              busy
);
    localparam int IW = $clog2(DATA_W);
    state_t state, state_next;
    logic [DATA_W-1:0] word;
    logic [IW-1:0] idx;
    logic id, last_grant, grant_a, grant_b, accept;
    logic [CNT_W-1:0] count;
    // A wins alone or on a tie when B was served last; B otherwise
    always_comb begin
        grant_a = a_valid & (~b_valid | last_grant == ID_B);
        grant_b = b_valid & ~grant_a;
        a_ready = state == IDLE & grant_a;
        b_ready = state == IDLE & grant_b;
        accept = a_ready | b_ready;
        bit_valid = state == SHIFT;
        bit_out = bit_valid & word[DATA_W-1];
        res_valid = state == DONE;
        res_id = res_valid & id;
        res_count = res_valid ? count : '0;
        busy = state != IDLE;
        state_next = state == IDLE ? (accept ? SHIFT : IDLE) :
                     state == SHIFT ? (idx == IW'(DATA_W-1) ? DONE : SHIFT) : IDLE;
    end
    // word shifts left so its MSB is always the current serial bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            word <= '0;
            idx <= '0;
            id <= ID_A;
            last_grant <= ID_B;
        end else begin
            state <= state_next;
            if (accept) begin
                word <= grant_b ? b_data : a_data;
                id <= grant_b ? ID_B : ID_A;
                last_grant <= grant_b ? ID_B : ID_A;
                idx <= '0;
            end else if (state == SHIFT) begin
                word <= {word[DATA_W-2:0], 1'b0};
                idx <= idx + 1'b1;
            end
        end
    end
    seq_match_core #(.PLEN(PLEN), .PATTERN(PATTERN), .CNT_W(CNT_W)) u_core (
        .clk(clk),
        .reset(reset),
        .clr(accept),
        .bit_valid(bit_valid),
        .bit_in(bit_out),
        .count(count)
    );
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: directed table-driven bench for seq_detect_sched
module tb_seq_detect_sched;
    logic clk = 0, reset = 1;
    logic a_valid = 0, b_valid = 0;
    logic [15:0] a_data = '0, b_data = '0;
    logic a_ready, b_ready, bit_valid, bit_out, res_valid, res_id, busy;
    logic [3:0] res_count;
    int n_checks = 0, n_fail = 0, cyc = 0;

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          cnt;
    } vec_t;
    vec_t vecs[9];

    seq_detect_sched dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .bit_valid(bit_valid), .bit_out(bit_out),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_outs"}, {a_ready, b_ready, bit_valid, bit_out, res_valid, res_id, res_count, busy}, '0);
    endtask

    // one word through the DUT with only its requester valid; checks serial stream and latency
    task automatic run_word(input logic id, input logic [15:0] d, input int exp_cnt, input int n);
        int t_acc, bad_bits;
        @(negedge clk);
        if (id) begin b_valid = 1; b_data = d; end
        else begin a_valid = 1; a_data = d; end
        #1;
        chk($sformatf("v%0d_ready", n), {a_ready, b_ready}, id ? 2'b01 : 2'b10);
        @(posedge clk);
        t_acc = cyc + 1;
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        bad_bits = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (!(bit_valid && bit_out == d[15-i] && !res_valid && busy && !a_ready && !b_ready)) bad_bits++;
        end
        chk($sformatf("v%0d_bits", n), bad_bits, 0);
        @(negedge clk);
        chk($sformatf("v%0d_latency", n), cyc - t_acc, 16);
        chk($sformatf("v%0d_res", n), {res_valid, res_id, res_count}, {1'b1, id, 4'(exp_cnt)});
        @(negedge clk);
        chk($sformatf("v%0d_after", n), {res_valid, busy}, 2'b00);
    endtask

    initial begin
        int got, t_prev;
        logic [3:0] ids;
        vecs[0] = '{1'b0, 16'hAC00, 1};
        vecs[1] = '{1'b1, 16'hAD60, 2};
        vecs[2] = '{1'b0, 16'h0000, 0};
        vecs[3] = '{1'b0, 16'hFFFF, 0};
        vecs[4] = '{1'b0, 16'h000A, 0};
        vecs[5] = '{1'b0, 16'hC000, 0};
        vecs[6] = '{1'b1, 16'hAD6B, 3};
        vecs[7] = '{1'b0, 16'hAEB5, 2};
        vecs[8] = '{1'b1, 16'h002B, 1};

        #2;
        chk_idle_outputs("reset");
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 9; k++) run_word(vecs[k].id, vecs[k].data, vecs[k].cnt, k);

        // both requesters held high from reset: alternate A,B,A,B with results 18 cycles apart
        @(negedge clk);
        reset = 1;
        a_valid = 1; a_data = 16'hAC00;
        b_valid = 1; b_data = 16'hAD6B;
        @(negedge clk);
        reset = 0;
        #1;
        chk("rr_first_grant", {a_ready, b_ready}, 2'b10);
        got = 0; t_prev = 0; ids = '0;
        for (int c = 0; c < 100 && got < 4; c++) begin
            @(negedge clk);
            if (a_ready && b_ready) chk("rr_both_ready", 1, 0);
            if (res_valid) begin
                ids[got] = res_id;
                chk($sformatf("rr_cnt%0d", got), res_count, res_id ? 4'd3 : 4'd1);
                if (got > 0) chk($sformatf("rr_gap%0d", got), cyc - t_prev, 18);
                t_prev = cyc;
                got++;
            end
        end
        chk("rr_results", got, 4);
        chk("rr_ids", ids, 4'b1010);
        a_valid = 0; b_valid = 0;

        // reset at idx 8 of an accepted word discards it
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        a_valid = 1; a_data = 16'hAC00;
        @(posedge clk);
        @(negedge clk);
        a_valid = 0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        #1;
        reset = 1;
        #1;
        chk_idle_outputs("midreset");
        @(negedge clk);
        reset = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid || busy) got++;
        end
        chk("midreset_no_result", got, 0);
        run_word(1'b0, 16'hAC00, 1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
